fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that feeds the decode/control path. It holds the program counter and issues word reads to instruction memory over a req/ack handshake. Returned instructions go into a 2-entry buffer, whose head provides the instruction, its PC and the opcode field to the main control decoder. Branch redirects from the execute path flush the buffer and restart fetch at the target.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- o_IMemReq  output  1  read request to instruction memory
- o_IMemAddr  output  32  word address of request, bits [1:0] always 00
- i_IMemAck  input  1  request completed; i_IMemData valid this cycle
- i_IMemData  input  32  instruction word returned with ack
- i_Branch  input  1  redirect pulse (taken branch), one cycle
- i_BranchTarget  input  32  redirect address, bits [1:0] ignored (forced 00)
- i_Stall  input  1  decode cannot accept the head entry this cycle
- o_Valid  output  1  buffer head is valid
- o_Instr  output  32  head instruction
- o_PC  output  32  address of head instruction
- o_OPCode  output  7  o_Instr[6:0], to main control

## Operation
- Registers: pc (next address to fetch), addr (in-flight address, drives o_IMemAddr), buffer of 2 {instr, pc} entries with count 0..2, and state.
- Consume: when o_Valid && !i_Stall, the head is popped.
- Push: when an ack is accepted in REQ, {i_IMemData, addr} is pushed, and pc <= pc + 4 (mod 2^32, wraps silently).
- At most one request is outstanding. A request is launched only when count-after-this-cycle <= 1, so an ack always has space.
- Handshake: once raised, o_IMemReq and o_IMemAddr stay stable until the cycle i_IMemAck is seen. Ack without req is ignored.
- States:
  - IDLE: no request. Go to REQ when count-after-this-cycle <= 1, loading addr <= pc.
  - REQ: o_IMemReq=1. On ack, push. Then stay in REQ with addr <= pc+4 if count-after <= 1, else go to IDLE.
  - DRAIN: o_IMemReq=1 with the stale addr. On ack, discard the data, load addr <= pc, and go to REQ.
- Redirect (i_Branch=1):
  - Buffer is flushed (count <= 0, o_Valid=0 next cycle) and pc <= {i_BranchTarget[31:2],2'b00}.
  - REQ without ack: go to DRAIN.
  - REQ with ack: ack data is dropped; addr <= target; stay in REQ.
  - IDLE: addr <= target; go to REQ.
  - DRAIN: pc is updated to the newest target; stay in DRAIN (ack still discarded).
- Priority: redirect > push/pop. Branch together with stall still flushes.

## Timing
- Reset, asynchronous: state=IDLE, pc=RESET_PC, addr=RESET_PC, count=0.
  - Outputs during reset: o_IMemReq=0, o_IMemAddr=RESET_PC, o_Valid=0, o_Instr=0, o_PC=0, o_OPCode=0.
- First o_IMemReq is in the second rising edge after reset release (one IDLE cycle).
- Ack in cycle N gives o_Valid in cycle N+1. With same-cycle ack and no stall, throughput is 1 instruction per cycle.
- Redirect in cycle N: o_Valid=0 in N+1.
  - From IDLE, or from REQ with ack in N: target request in N+1.
  - From REQ without ack: target request the cycle after the stale ack.
- Reset mid-request: request is dropped immediately. The memory must tolerate req falling without ack under reset.
- o_OPCode is combinational from the head register only; there are no input-to-output combinational paths.

## Structure
- Shared package (cpu_pkg): XLEN=32, INSTR_W=32, OPCODE_W=7, fetch state encoding (IDLE/REQ/DRAIN), PC_STEP=4.
- One sub-module is natural: fetch_buffer, a 2-entry synchronous FIFO with push/pop/flush, count and head outputs.

## Test plan
- Reset and stream: RESET_PC=0x100, memory acks every cycle returning addr^0xA5A5_0000.
  - o_IMemReq rises in cycle 2.
  - o_Valid from cycle 3 with o_PC=0x100,0x104,0x108 on consecutive cycles.
  - o_OPCode = data[6:0].
- Backpressure: hold i_Stall=1 for 5 cycles.
  - count saturates at 2; o_IMemReq deasserts; head stays 0x100.
  - On release, 0x100 and 0x104 drain in order with no lost or duplicate PC.
- Redirect with stale request: memory ack latency 3. Assert i_Branch, target 0x2002, one cycle after req.
  - o_IMemAddr stays stable until the ack; stale data is never presented.
  - Next request is 0x2000; first valid o_PC is 0x2000.
- Redirect + ack + stall in the same cycle:
  - Buffer flushed; ack data dropped; next o_IMemAddr is the target; o_Valid=0 next cycle.
- Double redirect during DRAIN: targets 0x300 then 0x400.
  - Only 0x400 is fetched after the stale ack.
- PC wrap and mid-run reset:
  - Fetch at 0xFFFF_FFFC yields next address 0x0000_0000.
  - Asserting i_rst_n=0 mid-request zeroes o_IMemReq/o_Valid asynchronously; restart at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, fetch state encoding and buffer entry type
package cpu_pkg;
  localparam int XLEN     = 32;
  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 7;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - 2-entry instruction buffer with push/pop/flush
module fetch_buffer
  import cpu_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  fetch_entry_t i_entry,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic [1:0]   o_count,
  output fetch_entry_t o_head
);

  logic [1:0]   r_count;
  fetch_entry_t r_head;
  fetch_entry_t r_tail;

  // Head is kept in its own register so decode sees it straight from a flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_entry;
          else                 r_tail <= i_entry;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= i_entry;
          end else begin
            r_head <= r_tail;
            r_tail <= i_entry;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_head;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC register, imem req/ack sequencer and redirect handling
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  output logic                o_IMemReq,
  output logic [XLEN-1:0]     o_IMemAddr,
  input  logic                i_IMemAck,
  input  logic [INSTR_W-1:0]  i_IMemData,
  input  logic                i_Branch,
  input  logic [XLEN-1:0]     i_BranchTarget,
  input  logic                i_Stall,
  output logic                o_Valid,
  output logic [INSTR_W-1:0]  o_Instr,
  output logic [XLEN-1:0]     o_PC,
  output logic [OPCODE_W-1:0] o_OPCode
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_addr;
  logic            r_req;

  logic [1:0]      w_count;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_entry;
  logic            w_pop;
  logic            w_push;
  logic [2:0]      w_count_after;
  logic            w_room;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc_inc;

  assign w_pop         = (w_count != 2'd0) && !i_Stall;
  assign w_push        = (r_state == ST_REQ) && i_IMemAck && !i_Branch;
  assign w_push_entry  = '{instr: i_IMemData, pc: r_addr};
  assign w_count_after = {1'b0, w_count} + {2'b00, w_push} - {2'b00, w_pop};
  assign w_room        = (w_count_after <= 3'd1);
  assign w_target      = word_align(i_BranchTarget);
  assign w_pc_inc      = r_pc + PC_STEP;

  fetch_buffer u_buffer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_entry (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (i_Branch),
    .o_count (w_count),
    .o_head  (w_head)
  );

  // Launching only when room remains after this cycle guarantees every ack can be pushed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
      r_req   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_Branch) begin
            r_pc    <= w_target;
            r_addr  <= w_target;
            r_state <= ST_REQ;
            r_req   <= 1'b1;
          end else if (w_room) begin
            r_addr  <= r_pc;
            r_state <= ST_REQ;
            r_req   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (i_Branch) begin
            r_pc <= w_target;
            if (i_IMemAck) r_addr  <= w_target;
            else           r_state <= ST_DRAIN;
          end else if (i_IMemAck) begin
            r_pc <= w_pc_inc;
            if (w_room) begin
              r_addr <= w_pc_inc;
            end else begin
              r_state <= ST_IDLE;
              r_req   <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          // The stale request must complete before the newest target is issued.
          if (i_Branch) r_pc <= w_target;
          if (i_IMemAck) begin
            r_addr  <= i_Branch ? w_target : r_pc;
            r_state <= ST_REQ;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign o_IMemReq  = r_req;
  assign o_IMemAddr = r_addr;
  assign o_Valid    = (w_count != 2'd0);
  assign o_Instr    = w_head.instr;
  assign o_PC       = w_head.pc;
  assign o_OPCode   = w_head.instr[OPCODE_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        i_clk;
  logic        i_rst_n;
  logic        o_IMemReq;
  logic [31:0] o_IMemAddr;
  logic        i_IMemAck;
  logic [31:0] i_IMemData;
  logic        i_Branch;
  logic [31:0] i_BranchTarget;
  logic        i_Stall;
  logic        o_Valid;
  logic [31:0] o_Instr;
  logic [31:0] o_PC;
  logic [6:0]  o_OPCode;

  int checks;
  int failures;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .o_IMemReq      (o_IMemReq),
    .o_IMemAddr     (o_IMemAddr),
    .i_IMemAck      (i_IMemAck),
    .i_IMemData     (i_IMemData),
    .i_Branch       (i_Branch),
    .i_BranchTarget (i_BranchTarget),
    .i_Stall        (i_Stall),
    .o_Valid        (o_Valid),
    .o_Instr        (o_Instr),
    .o_PC           (o_PC),
    .o_OPCode       (o_OPCode)
  );

  // Memory returns a word derived from the requested address.
  assign i_IMemData = o_IMemAddr ^ 32'hA5A5_0000;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    step();
    step();
    i_rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    i_rst_n = 1'b0;
    i_IMemAck = 1'b0;
    i_Branch = 1'b0;
    i_BranchTarget = 32'h0;
    i_Stall = 1'b0;

    // Reset state
    step();
    step();
    check("rst_req", {31'b0, o_IMemReq}, 32'd0);
    check("rst_addr", o_IMemAddr, 32'h0000_0100);
    check("rst_valid", {31'b0, o_Valid}, 32'd0);
    check("rst_instr", o_Instr, 32'h0);
    check("rst_pc", o_PC, 32'h0);
    check("rst_opcode", {25'b0, o_OPCode}, 32'h0);

    // Streaming with ack every cycle
    i_rst_n = 1'b1;
    i_IMemAck = 1'b1;
    step();
    check("s1_req", {31'b0, o_IMemReq}, 32'd1);
    check("s1_addr", o_IMemAddr, 32'h0000_0100);
    check("s1_valid", {31'b0, o_Valid}, 32'd0);
    step();
    check("s2_valid", {31'b0, o_Valid}, 32'd1);
    check("s2_pc", o_PC, 32'h0000_0100);
    check("s2_instr", o_Instr, 32'hA5A5_0100);
    check("s2_addr", o_IMemAddr, 32'h0000_0104);
    step();
    check("s3_pc", o_PC, 32'h0000_0104);
    check("s3_opcode", {25'b0, o_OPCode}, 32'h04);
    step();
    check("s4_pc", o_PC, 32'h0000_0108);
    check("s4_opcode", {25'b0, o_OPCode}, 32'h08);
    check("s4_valid", {31'b0, o_Valid}, 32'd1);

    // Backpressure
    i_Stall = 1'b1;
    do_reset();
    step();
    step();
    check("bp2_pc", o_PC, 32'h0000_0100);
    check("bp2_req", {31'b0, o_IMemReq}, 32'd1);
    step();
    check("bp3_req", {31'b0, o_IMemReq}, 32'd0);
    check("bp3_pc", o_PC, 32'h0000_0100);
    step();
    step();
    check("bp5_req", {31'b0, o_IMemReq}, 32'd0);
    check("bp5_pc", o_PC, 32'h0000_0100);
    check("bp5_valid", {31'b0, o_Valid}, 32'd1);
    i_Stall = 1'b0;
    step();
    check("bp6_pc", o_PC, 32'h0000_0104);
    check("bp6_req", {31'b0, o_IMemReq}, 32'd1);
    check("bp6_addr", o_IMemAddr, 32'h0000_0108);
    step();
    check("bp7_pc", o_PC, 32'h0000_0108);

    // Redirect with stale request, ack latency 3
    i_IMemAck = 1'b0;
    do_reset();
    step();
    check("rd1_addr", o_IMemAddr, 32'h0000_0100);
    i_Branch = 1'b1;
    i_BranchTarget = 32'h0000_2002;
    step();
    i_Branch = 1'b0;
    check("rd2_valid", {31'b0, o_Valid}, 32'd0);
    check("rd2_req", {31'b0, o_IMemReq}, 32'd1);
    check("rd2_addr", o_IMemAddr, 32'h0000_0100);
    step();
    check("rd3_addr", o_IMemAddr, 32'h0000_0100);
    i_IMemAck = 1'b1;
    step();
    i_IMemAck = 1'b0;
    check("rd4_addr", o_IMemAddr, 32'h0000_2000);
    check("rd4_valid", {31'b0, o_Valid}, 32'd0);
    step();
    check("rd5_valid", {31'b0, o_Valid}, 32'd0);
    step();
    check("rd6_addr", o_IMemAddr, 32'h0000_2000);
    i_IMemAck = 1'b1;
    step();
    i_IMemAck = 1'b0;
    check("rd7_valid", {31'b0, o_Valid}, 32'd1);
    check("rd7_pc", o_PC, 32'h0000_2000);
    check("rd7_instr", o_Instr, 32'hA5A5_2000);

    // Redirect + ack + stall together
    i_IMemAck = 1'b1;
    i_Branch = 1'b1;
    i_BranchTarget = 32'h0000_3000;
    i_Stall = 1'b1;
    step();
    i_Branch = 1'b0;
    i_Stall = 1'b0;
    check("ras_valid", {31'b0, o_Valid}, 32'd0);
    check("ras_addr", o_IMemAddr, 32'h0000_3000);
    check("ras_req", {31'b0, o_IMemReq}, 32'd1);
    step();
    check("ras2_pc", o_PC, 32'h0000_3000);
    check("ras2_instr", o_Instr, 32'hA5A5_3000);

    // Double redirect while draining
    i_IMemAck = 1'b0;
    i_Branch = 1'b1;
    i_BranchTarget = 32'h0000_0300;
    step();
    check("dd1_addr", o_IMemAddr, 32'h0000_3004);
    check("dd1_valid", {31'b0, o_Valid}, 32'd0);
    i_BranchTarget = 32'h0000_0400;
    step();
    i_Branch = 1'b0;
    check("dd2_addr", o_IMemAddr, 32'h0000_3004);
    i_IMemAck = 1'b1;
    step();
    check("dd3_addr", o_IMemAddr, 32'h0000_0400);
    check("dd3_valid", {31'b0, o_Valid}, 32'd0);
    step();
    check("dd4_pc", o_PC, 32'h0000_0400);
    check("dd4_instr", o_Instr, 32'hA5A5_0400);

    // PC wrap
    i_Branch = 1'b1;
    i_BranchTarget = 32'hFFFF_FFFE;
    step();
    i_Branch = 1'b0;
    check("wr1_addr", o_IMemAddr, 32'hFFFF_FFFC);
    step();
    i_IMemAck = 1'b0;
    check("wr2_pc", o_PC, 32'hFFFF_FFFC);
    check("wr2_addr", o_IMemAddr, 32'h0000_0000);
    check("wr2_instr", o_Instr, 32'h5A5A_FFFC);
    check("wr2_opcode", {25'b0, o_OPCode}, 32'h7C);
    step();
    check("wr3_req", {31'b0, o_IMemReq}, 32'd1);

    // Asynchronous reset mid-request
    #1;
    i_rst_n = 1'b0;
    #1;
    check("ar_req", {31'b0, o_IMemReq}, 32'd0);
    check("ar_valid", {31'b0, o_Valid}, 32'd0);
    check("ar_addr", o_IMemAddr, 32'h0000_0100);
    step();
    i_rst_n = 1'b1;
    step();
    check("ar1_addr", o_IMemAddr, 32'h0000_0100);
    check("ar1_req", {31'b0, o_IMemReq}, 32'd1);
    i_IMemAck = 1'b1;
    step();
    check("ar2_pc", o_PC, 32'h0000_0100);
    check("ar2_valid", {31'b0, o_Valid}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
